operand_stack: RTL and testbench
================================

# operand_stack

Parametrised WebAssembly operand stack with a built-in integer comparison unit. It holds the CPU's value stack, executes push, drop and the full i32/i64 comparison family (eqz, eq, ne, lt, gt, le, ge, signed and unsigned) in place, and drives the `result`/`result_empty`/`trap` outputs the CPU exposes to its benches. It generalises the fixed 64-bit `eq` path to configurable width, depth and per-operation i32/i64 mode, and adds underflow, overflow and invalid-op traps.

## Interface
- `WIDTH`, 64: value width; legal values are 32 or 64.
- `DEPTH`, 16: maximum stack entries; a power of two, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  an operation is presented this cycle.
- `op`  in  4  operation code (see Operation).
- `is64`  in  1  1 selects i64 semantics, 0 selects i32. Ignored (treated as 0) when WIDTH=32.
- `push_data`  in  WIDTH  value to push for PUSH.
- `result`  out  WIDTH  registered top of stack; 0 when the stack is empty.
- `result_empty`  out  1  stack holds no entries.
- `full`  out  1  count equals DEPTH.
- `count`  out  $clog2(DEPTH+1)  number of live entries.
- `trap`  out  4  sticky trap code; 0 means none.

## Operation
- Op codes: 0 NOP, 1 PUSH, 2 DROP, 3 EQZ, 4 EQ, 5 NE, 6 LT_S, 7 LT_U, 8 GT_S, 9 GT_U, 10 LE_S, 11 LE_U, 12 GE_S, 13 GE_U. Codes 14 and 15 are invalid.
- An op is accepted when `op_valid`=1 and `trap`=0. While `trap`≠0, all ops are ignored and the state is frozen.
- PUSH: stores `push_data`. When i32 mode is in effect, bits above 31 are cleared before storing. Count increments.
- DROP: removes the top entry. Count decrements.
- EQZ: pops one value and pushes 1 if it is zero, else 0. Count is unchanged.
- Binary compares: a = entry below top, b = top. Pops both, pushes the result of a OP b as 0 or 1, zero-extended to WIDTH. Count decrements by 1.
- Mode: i64 compares all 64 bits with the sign at bit 63. i32 compares bits 31:0 only, with the sign at bit 31, and ignores the upper bits.
- Trap codes:
  - 1 underflow: DROP or EQZ with count 0, or a binary op with count < 2.
  - 2 overflow: PUSH with count = DEPTH.
  - 3 invalid op code.
- A trapping op leaves the stack contents and count unchanged. The trap code latches until reset.
- NOP, and cycles with `op_valid`=0, change nothing.
- Storage: top of stack is held in a register that drives `result`. The remaining entries live in an array indexed by count; a next-of-stack register is permitted.

## Timing
- Reset asserted (low): immediately, with no clock edge, `result`=0, `result_empty`=1, `full`=0, `count`=0, `trap`=0. Array contents need not be cleared.
- Reset deassertion is synchronised upstream. The first op is accepted on the first rising edge with reset high.
- Reset asserted mid-operation aborts the op in flight; no partial update is visible.
- Latency is 1 cycle: the op accepted at edge N is reflected on all outputs after edge N. Throughput is one op per cycle, and back-to-back dependent ops (e.g. PUSH, PUSH, EQ on consecutive edges) are legal.
- `trap` goes nonzero after the edge that accepts the faulting op. `result` and `count` hold their pre-fault values.
- Count boundaries:
  - `full` asserts after the edge where count reaches DEPTH.
  - `result_empty` asserts after the edge where count reaches 0; `result` reads 0 in that state.
- No wrap-around: count never exceeds DEPTH and never goes below 0.

## Test plan
- i64 equal. WIDTH=64, is64=1. PUSH 5, PUSH 5, EQ on consecutive edges. After the third edge: `result`=1, `result_empty`=0, `count`=1, `trap`=0.
- Signed vs unsigned, i64. PUSH 64'hFFFF_FFFF_FFFF_FFFF, PUSH 1.
  - LT_S: `result`=1.
  - Repeat with LT_U: `result`=0.
  - Repeat with GE_U: `result`=1.
- i32 mode. is64=0. PUSH 64'h0000_0001_8000_0000, which is stored as 32'h8000_0000. PUSH 1.
  - LT_S: `result`=1.
  - Repeat with LT_U: `result`=0.
  - EQZ on a stored 0: `result`=1, `count` unchanged.
- Underflow. PUSH 7, then EQ. Required: `trap`=1, `count`=1, `result`=7. A subsequent PUSH 9 is ignored (`count` stays 1).
- Overflow and invalid op. DEPTH=4.
  - Five PUSHes: `full`=1 after the fourth edge, `trap`=2 after the fifth, `count`=4.
  - After reset, op 15: `trap`=3, `count`=0.
- Asynchronous reset mid-run. With count=3 and `trap`=0, drive reset low between clock edges. Required: `result`=0, `result_empty`=1, `count`=0 with no clock edge. After release, PUSH 2: `result`=2.

Source files
------------

// File: rtl/operand_stack_if.sv
// operand_stack_if: op request and stack status bundle between a CPU core and its operand stack.
interface operand_stack_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
);
    logic                         op_valid;
    logic [3:0]                   op;
    logic                         is64;
    logic [WIDTH-1:0]             push_data;
    logic [WIDTH-1:0]             result;
    logic                         result_empty;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [3:0]                   trap;
    modport master (output op_valid, op, is64, push_data,
                    input  result, result_empty, full, count, trap);
    modport slave  (input  op_valid, op, is64, push_data,
                    output result, result_empty, full, count, trap);
endinterface

// File: rtl/operand_stack.sv
// operand_stack: WebAssembly value stack with in-place i32/i64 comparisons and sticky traps.
module operand_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    operand_stack_if.slave s
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    // Top lives in top_q; entries below it sit in mem[0 .. count-2].
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] top_q, top_d, a, b, a_u, b_u, a_s, b_s, pdata;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       trap_q, trap_d, fault;
    logic [AW-1:0]    i1, i2;
    logic [15:0]      res_v;
    logic             w64, lt_s, lt_u, gt_s, gt_u, eq, zb, binary, pop1, go, ok, mem_we;
    always_comb begin
        w64    = (WIDTH == 64) && s.is64;
        i1     = AW'(count_q) - AW'(1);
        i2     = AW'(count_q) - AW'(2);
        a      = mem[i2];
        b      = top_q;
        a_u    = w64 ? a : WIDTH'(a[31:0]);
        b_u    = w64 ? b : WIDTH'(b[31:0]);
        a_s    = w64 ? a : WIDTH'($signed(a[31:0]));
        b_s    = w64 ? b : WIDTH'($signed(b[31:0]));
        pdata  = w64 ? s.push_data : WIDTH'(s.push_data[31:0]);
        lt_s   = $signed(a_s) < $signed(b_s);
        gt_s   = $signed(b_s) < $signed(a_s);
        lt_u   = a_u < b_u;
        gt_u   = b_u < a_u;
        eq     = a_u == b_u;
        zb     = b_u == '0;
        res_v  = {2'b00, !lt_u, !lt_s, !gt_u, !gt_s, gt_u, gt_s, lt_u, lt_s, !eq, eq, zb, 3'b000};
        binary = s.op >= 4'd4 && s.op <= 4'd13;
        pop1   = s.op == 4'd2 || s.op == 4'd3;
        fault  = s.op >= 4'd14                                            ? 4'd3 :
                 (s.op == 4'd1 && count_q == CW'(DEPTH))                  ? 4'd2 :
                 ((pop1 && count_q == '0) || (binary && count_q < CW'(2))) ? 4'd1 : 4'd0;
        go     = s.op_valid && trap_q == '0;
        ok     = go && fault == '0;
        trap_d = go ? fault : trap_q;
        mem_we = ok && s.op == 4'd1 && count_q != '0;
        top_d  = !ok                 ? top_q :
                 s.op == 4'd1        ? pdata :
                 s.op == 4'd2        ? (count_q == CW'(1) ? '0 : a) :
                 (binary || pop1)    ? WIDTH'(res_v[s.op]) : top_q;
        count_d = !ok                      ? count_q :
                  s.op == 4'd1             ? count_q + CW'(1) :
                  (s.op == 4'd2 || binary) ? count_q - CW'(1) : count_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q   <= '0;
            count_q <= '0;
            trap_q  <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            trap_q  <= trap_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[i1] <= top_q;
    end
    assign s.result       = top_q;
    assign s.count        = count_q;
    assign s.trap         = trap_q;
    assign s.result_empty = count_q == '0;
    assign s.full         = count_q == CW'(DEPTH);
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed vector table plus hand sequences for traps and async reset.
module tb_operand_stack;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    always #5 clk = ~clk;
    operand_stack_if #(.WIDTH(64), .DEPTH(4)) s ();
    operand_stack #(.WIDTH(64), .DEPTH(4)) dut (.clk(clk), .reset(reset), .s(s.slave));
    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic        w;
        logic [63:0] d;
        logic [63:0] r;
        int          c;
        logic [3:0]  t;
    } vec_t;
    vec_t tv[$];
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] I32V = 64'h0000_0001_8000_0000;
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask
    task automatic chk_state(input string n, input logic [63:0] r, input int c, input logic [3:0] t);
        chk({n, ".result"}, s.result, r);
        chk({n, ".count"}, 64'(s.count), 64'(c));
        chk({n, ".trap"}, 64'(s.trap), 64'(t));
        chk({n, ".empty"}, 64'(s.result_empty), 64'(c == 0));
        chk({n, ".full"}, 64'(s.full), 64'(c == 4));
    endtask
    task automatic apply(input logic v, input logic [3:0] op, input logic w, input logic [63:0] d);
        @(negedge clk);
        s.op_valid  = v;
        s.op        = op;
        s.is64      = w;
        s.push_data = d;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        @(negedge clk);
        s.op_valid = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        s.op_valid = 1'b0;
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask
    initial begin
        s.op_valid = 1'b0; s.op = 4'd0; s.is64 = 1'b1; s.push_data = '0;
        #2;
        chk_state("reset", 64'd0, 0, 4'd0);
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd5, 64'd5, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd5, 64'd5, 2, 4'd0});
        tv.push_back('{1'b1, 4'd4,  1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, ALL1,  ALL1,  1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd6,  1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, ALL1,  ALL1,  1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd7,  1'b1, 64'd0, 64'd0, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, ALL1,  ALL1,  1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd13, 1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b0, I32V,  64'h8000_0000, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b0, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd6,  1'b0, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b0, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b0, I32V,  64'h8000_0000, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b0, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd7,  1'b0, 64'd0, 64'd0, 1, 4'd0});
        tv.push_back('{1'b1, 4'd3,  1'b0, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd3,  1'b0, 64'd0, 64'd0, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 2, 4'd0});
        tv.push_back('{1'b1, 4'd3,  1'b0, 64'd0, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd3,  1'b1, 64'd0, 64'd0, 2, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd2, 64'd2, 3, 4'd0});
        tv.push_back('{1'b1, 4'd5,  1'b1, 64'd0, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd10, 1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd12, 1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd8,  1'b1, 64'd0, 64'd0, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd1, 64'd1, 2, 4'd0});
        tv.push_back('{1'b1, 4'd11, 1'b1, 64'd0, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd0,  1'b1, 64'd7, 64'd1, 1, 4'd0});
        tv.push_back('{1'b0, 4'd1,  1'b1, 64'd99, 64'd1, 1, 4'd0});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd0, 0, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd10, 64'd10, 1, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd11, 64'd11, 2, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd12, 64'd12, 3, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd13, 64'd13, 4, 4'd0});
        tv.push_back('{1'b1, 4'd1,  1'b1, 64'd14, 64'd13, 4, 4'd2});
        tv.push_back('{1'b1, 4'd2,  1'b1, 64'd0, 64'd13, 4, 4'd2});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i].v, tv[i].op, tv[i].w, tv[i].d);
            chk_state($sformatf("row%0d", i), tv[i].r, tv[i].c, tv[i].t);
        end
        do_reset();
        apply(1'b1, 4'd1, 1'b1, 64'd7);
        apply(1'b1, 4'd4, 1'b1, 64'd0);
        chk_state("underflow", 64'd7, 1, 4'd1);
        apply(1'b1, 4'd1, 1'b1, 64'd9);
        chk_state("frozen", 64'd7, 1, 4'd1);
        do_reset();
        apply(1'b1, 4'd2, 1'b1, 64'd0);
        chk_state("drop_empty", 64'd0, 0, 4'd1);
        do_reset();
        apply(1'b1, 4'd15, 1'b1, 64'd0);
        chk_state("invalid", 64'd0, 0, 4'd3);
        do_reset();
        apply(1'b1, 4'd1, 1'b1, 64'd4);
        apply(1'b1, 4'd1, 1'b1, 64'd5);
        apply(1'b1, 4'd1, 1'b1, 64'd6);
        chk_state("pre_async", 64'd6, 3, 4'd0);
        s.op_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk_state("async", 64'd0, 0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        apply(1'b1, 4'd1, 1'b1, 64'd2);
        chk_state("post_async", 64'd2, 1, 4'd0);
        idle();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
